// File: rtl/wb_write_queue_if.sv
// Write-request, register-file write and forwarding-lookup signals of wb_write_queue.
// slave is the queue side; master is the pipeline/testbench side.
interface wb_write_queue_if #(parameter int unsigned DEPTH = 4);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          in_valid_a;
   logic          in_ready_a;
   logic [4:0]    in_addr_a;
   logic [31:0]   in_data_a;
   logic          in_valid_b;
   logic          in_ready_b;
   logic [4:0]    in_addr_b;
   logic [31:0]   in_data_b;
   logic          stallW;
   logic          we;
   logic [4:0]    waddr;
   logic [31:0]   wdata;
   logic [4:0]    fwd_addr1;
   logic [4:0]    fwd_addr2;
   logic          fwd_hit1;
   logic          fwd_hit2;
   logic [31:0]   fwd_data1;
   logic [31:0]   fwd_data2;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   modport slave (
      input  in_valid_a, in_addr_a, in_data_a,
      input  in_valid_b, in_addr_b, in_data_b,
      input  stallW, fwd_addr1, fwd_addr2,
      output in_ready_a, in_ready_b,
      output we, waddr, wdata,
      output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
      output count, full, empty
   );

   modport master (
      output in_valid_a, in_addr_a, in_data_a,
      output in_valid_b, in_addr_b, in_data_b,
      output stallW, fwd_addr1, fwd_addr2,
      input  in_ready_a, in_ready_b,
      input  we, waddr, wdata,
      input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
      input  count, full, empty
   );
endinterface

// File: rtl/wb_write_queue.sv
// Two-source register-file write queue: circular FIFO of {addr, data} with
// combinational head presentation and youngest-match forwarding lookup.
module wb_write_queue #(
   parameter int unsigned DEPTH = 4
) (
   input logic             clk,
   input logic             rst,
   wb_write_queue_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [AW-1:0]    head_q;
   logic [AW-1:0]    tail_q;
   logic [CW-1:0]    count_q;
   logic [DEPTH-1:0] valid_q;
   logic [4:0]       addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];

   logic [CW-1:0] free_c;
   logic [CW-1:0] count_next;
   logic          empty_c;
   logic          ready_a;
   logic          ready_b;
   logic          push_a;
   logic          push_b;
   logic          pop;
   logic [AW-1:0] slot_b;

   // B needs two free slots when A may also claim one this cycle
   assign free_c     = CW'(DEPTH) - count_q;
   assign empty_c    = (count_q == '0);
   assign ready_a    = (free_c >= CW'(1));
   assign ready_b    = (free_c >= CW'(2)) || (ready_a && !bus.in_valid_a);
   assign push_a     = bus.in_valid_a && ready_a && (bus.in_addr_a != 5'd0);
   assign push_b     = bus.in_valid_b && ready_b && (bus.in_addr_b != 5'd0);
   assign pop        = !empty_c && !bus.stallW;
   assign slot_b     = push_a ? AW'(tail_q + AW'(1)) : tail_q;
   assign count_next = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);

   // Pointers, occupancy and per-slot valid bits
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= AW'(head_q + AW'(1));
         end
         if (push_a) valid_q[tail_q] <= 1'b1;
         if (push_b) valid_q[slot_b] <= 1'b1;
         tail_q  <= AW'(tail_q + AW'(push_a) + AW'(push_b));
         count_q <= count_next;
      end
   end

   // Entry payload; a push never targets the occupied head slot
   always_ff @(posedge clk) begin
      if (push_a) begin
         addr_q[tail_q] <= bus.in_addr_a;
         data_q[tail_q] <= bus.in_data_a;
      end
      if (push_b) begin
         addr_q[slot_b] <= bus.in_addr_b;
         data_q[slot_b] <= bus.in_data_b;
      end
   end

   logic [AW-1:0] idx;
   logic          hit1;
   logic          hit2;
   logic [31:0]   fd1;
   logic [31:0]   fd2;

   // Walk oldest to youngest so the last match wins
   always_comb begin
      idx  = '0;
      hit1 = 1'b0;
      hit2 = 1'b0;
      fd1  = '0;
      fd2  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = AW'(head_q + AW'(i));
         if (valid_q[idx] && (bus.fwd_addr1 != 5'd0) && (addr_q[idx] == bus.fwd_addr1)) begin
            hit1 = 1'b1;
            fd1  = data_q[idx];
         end
         if (valid_q[idx] && (bus.fwd_addr2 != 5'd0) && (addr_q[idx] == bus.fwd_addr2)) begin
            hit2 = 1'b1;
            fd2  = data_q[idx];
         end
      end
   end

   assign bus.in_ready_a = ready_a;
   assign bus.in_ready_b = ready_b;
   assign bus.we         = !empty_c;
   assign bus.waddr      = empty_c ? 5'd0  : addr_q[head_q];
   assign bus.wdata      = empty_c ? 32'd0 : data_q[head_q];
   assign bus.fwd_hit1   = hit1;
   assign bus.fwd_hit2   = hit2;
   assign bus.fwd_data1  = fd1;
   assign bus.fwd_data2  = fd2;
   assign bus.count      = count_q;
   assign bus.full       = (count_q == CW'(DEPTH));
   assign bus.empty      = empty_c;
endmodule
